gba_timer_bank: RTL

Parametrised GBA-style timer bank that replaces the fixed four-timer logic inside the IO register file. It provides NUM_TIMERS up-counters with a shared 16.78 MHz tick, 1/64/256/1024 prescalers, cascade mode, reload-on-overflow and per-timer interrupt and overflow pulses. It sits behind the IO register decoder at 0x100 + 4·n and feeds the interrupt controller and the direct-sound FIFOs.

---
 rtl/gba_timer_pkg.sv | 37 +++
 rtl/gba_timer_channel.sv | 89 ++++++++
 rtl/gba_timer_bank.sv | 76 +++++++
 3 files changed

// File: rtl/gba_timer_pkg.sv
// Shared constants for the GBA-style timer bank.
// Prescale encodings/limits, control bit positions, divider width helper.
package gba_timer_pkg;

  localparam logic [1:0] PS_1    = 2'd0;
  localparam logic [1:0] PS_64   = 2'd1;
  localparam logic [1:0] PS_256  = 2'd2;
  localparam logic [1:0] PS_1024 = 2'd3;

  localparam logic [9:0] LIM_1    = 10'd0;
  localparam logic [9:0] LIM_64   = 10'd63;
  localparam logic [9:0] LIM_256  = 10'd255;
  localparam logic [9:0] LIM_1024 = 10'd1023;

  localparam int CTRL_CASCADE = 2;
  localparam int CTRL_IRQ     = 6;
  localparam int CTRL_EN      = 7;

  // Only prescale, cascade, irq enable and enable are stored.
  localparam logic [7:0] CTRL_MASK = 8'hC7;

  function automatic logic [9:0] ps_limit(input logic [1:0] ps);
    logic [9:0] lim;
    unique case (ps)
      PS_1:    lim = LIM_1;
      PS_64:   lim = LIM_64;
      PS_256:  lim = LIM_256;
      default: lim = LIM_1024;
    endcase
    return lim;
  endfunction

  function automatic int div_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gba_timer_channel.sv
// One timer channel: counter, reload, control, prescaler, overflow.
// Ports: tick/casc_in in, write controls in, ovf_comb/irq/ovf/rd_word out.
module gba_timer_channel
  import gba_timer_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter bit CASC_OK   = 1'b1
) (
  input  logic        clk_mem,
  input  logic        rst,
  input  logic        tick,
  input  logic        casc_in,
  input  logic        wr,
  input  logic [2:0]  wstrb,
  input  logic [23:0] wdata,
  output logic        ovf_comb,
  output logic        irq,
  output logic        ovf,
  output logic [31:0] rd_word
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] rld_q, rld_d;
  logic [7:0]           ctrl_q, ctrl_d;
  logic [9:0]           pre_q, pre_d;
  logic                 irq_q, irq_d;
  logic                 ovf_q, ovf_d;

  logic [15:0] rld16;
  logic        wr_hi, start, stop, cascade;
  logic        pre_hit, tick_run, inc;

  always_comb begin
    rld16 = 16'(rld_q);
    if (wr && wstrb[0]) rld16[7:0]  = wdata[7:0];
    if (wr && wstrb[1]) rld16[15:8] = wdata[15:8];
    rld_d = rld16[CNT_WIDTH-1:0];

    wr_hi  = wr && wstrb[2];
    ctrl_d = wr_hi ? (wdata[23:16] & CTRL_MASK) : ctrl_q;
    start  = wr_hi && !ctrl_q[CTRL_EN] && ctrl_d[CTRL_EN];
    // A write that clears enable freezes the counter this very cycle.
    stop   = wr_hi && !ctrl_d[CTRL_EN];

    cascade  = CASC_OK && ctrl_q[CTRL_CASCADE];
    // >= so a prescale change mid-count cannot strand the counter.
    pre_hit  = pre_q >= ps_limit(ctrl_q[1:0]);
    tick_run = ctrl_q[CTRL_EN] && !stop && !cascade && tick;
    inc      = ctrl_q[CTRL_EN] && !stop &&
               (cascade ? casc_in : (tick && pre_hit));
    ovf_comb = inc && (&cnt_q);

    cnt_d = cnt_q;
    pre_d = pre_q;
    if (start) begin
      cnt_d = rld_d;
      pre_d = '0;
    end else begin
      if (tick_run) pre_d = pre_hit ? '0 : pre_q + 10'd1;
      if (inc)      cnt_d = ovf_comb ? rld_d : cnt_q + 1'b1;
    end

    ovf_d = ovf_comb;
    irq_d = ovf_comb && ctrl_q[CTRL_IRQ];
  end

  always_ff @(posedge clk_mem) begin
    if (rst) begin
      cnt_q  <= '0;
      rld_q  <= '0;
      ctrl_q <= '0;
      pre_q  <= '0;
      irq_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rld_q  <= rld_d;
      ctrl_q <= ctrl_d;
      pre_q  <= pre_d;
      irq_q  <= irq_d;
      ovf_q  <= ovf_d;
    end
  end

  assign irq     = irq_q;
  assign ovf     = ovf_q;
  assign rd_word = {8'h00, ctrl_q, 16'(cnt_q)};

endmodule

// File: rtl/gba_timer_bank.sv
// Bank of NUM_TIMERS GBA timers: tick divider, write decode, read mux.
// Ports: bus (sel/write/idx/wstrb/wdata/rdata), irq/ovf pulse vectors.
module gba_timer_bank
  import gba_timer_pkg::*;
#(
  parameter int NUM_TIMERS = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int TICK_DIV   = 3
) (
  input  logic                  clk_mem,
  input  logic                  rst,
  input  logic                  sel,
  input  logic                  write,
  input  logic [2:0]            idx,
  input  logic [3:0]            wstrb,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic [NUM_TIMERS-1:0] irq,
  output logic [NUM_TIMERS-1:0] ovf
);

  localparam int DW = div_width(TICK_DIV);

  logic [DW-1:0] div_q, div_d;
  logic          tick;

  always_comb begin
    tick  = (div_q == DW'(TICK_DIV - 1));
    div_d = tick ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk_mem) begin
    if (rst) div_q <= '0;
    else     div_q <= div_d;
  end

  logic [NUM_TIMERS-1:0] wr_vec;
  logic [NUM_TIMERS-1:0] ovf_comb;
  logic [NUM_TIMERS:0]   chain;
  logic [31:0]           rd_arr [NUM_TIMERS];

  // Channel n cascades off channel n-1's same-cycle overflow.
  assign chain = {ovf_comb, 1'b0};

  for (genvar gi = 0; gi < NUM_TIMERS; gi++) begin : g_ch
    assign wr_vec[gi] = sel && write && (idx == 3'(gi));

    gba_timer_channel #(
      .CNT_WIDTH (CNT_WIDTH),
      .CASC_OK   (gi > 0)
    ) u_ch (
      .clk_mem  (clk_mem),
      .rst      (rst),
      .tick     (tick),
      .casc_in  (chain[gi]),
      .wr       (wr_vec[gi]),
      .wstrb    (wstrb[2:0]),
      .wdata    (wdata[23:0]),
      .ovf_comb (ovf_comb[gi]),
      .irq      (irq[gi]),
      .ovf      (ovf[gi]),
      .rd_word  (rd_arr[gi])
    );
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (idx == 3'(i)) rdata = rd_arr[i];
    end
  end

  logic unused_ok;
  assign unused_ok = ^{wdata[31:24], wstrb[3], chain[NUM_TIMERS]};

endmodule
